// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the APB GPIO controller: register offsets and size limits.
// Latency: none (package only).
// Backpressure: not applicable.
package gpio_ctrl_pkg;

  localparam int SEG_W    = 8;
  localparam int MAX_GPIO = 32;
  localparam int MAX_SEG  = 8;

  localparam logic [7:0] OFF_OUT    = 8'h00;
  localparam logic [7:0] OFF_IN     = 8'h04;
  localparam logic [7:0] OFF_OE     = 8'h08;
  localparam logic [7:0] OFF_SEG_LO = 8'h0C;
  localparam logic [7:0] OFF_SEG_HI = 8'h10;
  localparam logic [7:0] OFF_IE     = 8'h14;
  localparam logic [7:0] OFF_IS     = 8'h18;
  localparam logic [7:0] OFF_POL    = 8'h1C;

  // Expand the four APB byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Per-bit reset-to-0 flop chain bringing asynchronous pin inputs into the clock domain.
// Latency: STAGES clock edges from d to q.
// Backpressure: none; samples every cycle.
module gpio_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  // Shift the chain by one stage, new sample entering at stage 0.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d;
    for (int s = 1; s < STAGES; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  // Chain registers, cleared on reset so the output reads 0 until refilled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stage_q <= '0;
    else          stage_q <= stage_d;
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl_apb.sv
// Zero-wait-state APB3 GPIO controller: OUT/OE/SEG registers, synced IN, optional edge IRQ (GPIO_IRQ_EN).
// Latency: writes land on the edge ending the access phase; IN lags pins by SYNC_STAGES edges.
// Backpressure: none; pready = psel & penable, errors reported via pslverr.
module gpio_ctrl_apb
  import gpio_ctrl_pkg::*;
#(
  parameter int NUM_GPIO    = 16,
  parameter int NUM_SEG     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [31:0]              in_paddr,
  input  logic                     in_psel,
  input  logic                     in_penable,
  input  logic [2:0]               in_pprot,
  input  logic                     in_pwrite,
  input  logic [31:0]              in_pwdata,
  input  logic [3:0]               in_pstrb,
  output logic                     in_pready,
  output logic [31:0]              in_prdata,
  output logic                     in_pslverr,
  output logic [NUM_GPIO-1:0]      gpio_out,
  output logic [NUM_GPIO-1:0]      gpio_oe,
  input  logic [NUM_GPIO-1:0]      gpio_in,
  output logic [NUM_SEG*SEG_W-1:0] gpio_seg,
  output logic                     gpio_irq
);

  logic                      access;
  logic [7:0]                offset;
  logic                      hit_out, hit_in, hit_oe, hit_seg_lo, hit_seg_hi;
  logic                      hit_ie, hit_is, hit_pol;
  logic                      mapped, err, wr_ok;
  logic [31:0]               wmask;
  logic [31:0]               rdata;
  logic [NUM_GPIO-1:0]       sync_in;
  logic [NUM_GPIO-1:0]       out_q, out_d, oe_q, oe_d;
  logic [NUM_SEG*SEG_W-1:0]  seg_q, seg_d;

  assign access    = in_psel & in_penable;
  assign offset    = in_paddr[7:0];
  assign wmask     = strb_mask(in_pstrb);
  assign in_pready = access;

  gpio_sync #(.WIDTH(NUM_GPIO), .STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (gpio_in),
    .q       (sync_in)
  );

  // Address decode and error classification; an erroring access touches no state.
  always_comb begin
    hit_out    = (offset == OFF_OUT);
    hit_in     = (offset == OFF_IN);
    hit_oe     = (offset == OFF_OE);
    hit_seg_lo = (offset == OFF_SEG_LO);
    hit_seg_hi = (offset == OFF_SEG_HI);
`ifdef GPIO_IRQ_EN
    hit_ie     = (offset == OFF_IE);
    hit_is     = (offset == OFF_IS);
    hit_pol    = (offset == OFF_POL);
`else
    hit_ie     = 1'b0;
    hit_is     = 1'b0;
    hit_pol    = 1'b0;
`endif
    mapped = hit_out | hit_in | hit_oe | hit_seg_lo | hit_seg_hi | hit_ie | hit_is | hit_pol;
    err    = (in_paddr[1:0] != 2'b00) | ~mapped | (in_pwrite & hit_in);
    wr_ok  = access & in_pwrite & ~err;
  end

  // Byte-strobed next state for OUT, OE and the segment digits.
  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    seg_d = seg_q;
    if (wr_ok && hit_out)
      out_d = (out_q & ~wmask[NUM_GPIO-1:0]) | (in_pwdata[NUM_GPIO-1:0] & wmask[NUM_GPIO-1:0]);
    if (wr_ok && hit_oe)
      oe_d = (oe_q & ~wmask[NUM_GPIO-1:0]) | (in_pwdata[NUM_GPIO-1:0] & wmask[NUM_GPIO-1:0]);
    // Digits 0-3 live in SEG_LO, 4-7 in SEG_HI; digit k uses byte lane k%4.
    for (int k = 0; k < NUM_SEG; k++) begin
      if (wr_ok && in_pstrb[2'(k % 4)] && ((k < 4) ? hit_seg_lo : hit_seg_hi))
        seg_d[k*SEG_W +: SEG_W] = in_pwdata[(k % 4)*SEG_W +: SEG_W];
    end
  end

  // Register file state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
      oe_q  <= '0;
      seg_q <= '0;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
      seg_q <= seg_d;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [NUM_GPIO-1:0] ie_q, ie_d, is_q, is_d, pol_q, pol_d, prev_q, prev_d, edge_hit;

  // Edge detect on the synced input; a detected edge beats a same-cycle W1C clear.
  always_comb begin
    ie_d     = ie_q;
    pol_d    = pol_q;
    prev_d   = sync_in;
    edge_hit = (pol_q & sync_in & ~prev_q) | (~pol_q & ~sync_in & prev_q);
    is_d     = is_q;
    if (wr_ok && hit_ie)
      ie_d = (ie_q & ~wmask[NUM_GPIO-1:0]) | (in_pwdata[NUM_GPIO-1:0] & wmask[NUM_GPIO-1:0]);
    if (wr_ok && hit_pol)
      pol_d = (pol_q & ~wmask[NUM_GPIO-1:0]) | (in_pwdata[NUM_GPIO-1:0] & wmask[NUM_GPIO-1:0]);
    if (wr_ok && hit_is)
      is_d = is_q & ~(in_pwdata[NUM_GPIO-1:0] & wmask[NUM_GPIO-1:0]);
    is_d = is_d | edge_hit;
  end

  // Interrupt enable, status, polarity and previous-sample registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ie_q   <= '0;
      is_q   <= '0;
      pol_q  <= '0;
      prev_q <= '0;
    end else begin
      ie_q   <= ie_d;
      is_q   <= is_d;
      pol_q  <= pol_d;
      prev_q <= prev_d;
    end
  end

  assign gpio_irq = |(is_q & ie_q);
`else
  assign gpio_irq = 1'b0;
`endif

  // Read mux; unimplemented bits and absent digits read as 0.
  always_comb begin
    rdata = '0;
    if (hit_out) rdata[NUM_GPIO-1:0] = out_q;
    if (hit_in)  rdata[NUM_GPIO-1:0] = sync_in;
    if (hit_oe)  rdata[NUM_GPIO-1:0] = oe_q;
    for (int k = 0; k < NUM_SEG; k++) begin
      if ((k < 4) ? hit_seg_lo : hit_seg_hi)
        rdata[(k % 4)*SEG_W +: SEG_W] = seg_q[k*SEG_W +: SEG_W];
    end
`ifdef GPIO_IRQ_EN
    if (hit_ie)  rdata[NUM_GPIO-1:0] = ie_q;
    if (hit_is)  rdata[NUM_GPIO-1:0] = is_q;
    if (hit_pol) rdata[NUM_GPIO-1:0] = pol_q;
`endif
  end

  assign in_prdata  = (access && !in_pwrite && !err) ? rdata : 32'h0;
  assign in_pslverr = access & err;
  assign gpio_out   = out_q;
  assign gpio_oe    = oe_q;
  assign gpio_seg   = seg_q;

  // Protection bits, upper address bits and unused strobe-mask bits are don't-cares.
  logic unused_ok;
  assign unused_ok = &{1'b0, in_pprot, in_paddr[31:8], wmask};

endmodule
